// File: rtl/counter_xn.sv
// ============================================================================
//  Module      : counter_xn
//  Description : NCH independent prescaled down-counters with one-shot,
//                auto-reload and PWM modes, sticky status and register access.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module counter_xn #(
    parameter int NCH   = 3,
    parameter int WIDTH = 32,
    parameter int PSW   = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 we,
    input  logic [2:0]           ch,
    input  logic [1:0]           reg_sel,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic [NCH*WIDTH-1:0] cnt_out,
    output logic [NCH-1:0]       irq,
    output logic [NCH-1:0]       pwm
);

    localparam logic [1:0] C_SEL_LOAD   = 2'd0;
    localparam logic [1:0] C_SEL_CMP    = 2'd1;
    localparam logic [1:0] C_SEL_CTRL   = 2'd2;
    localparam logic [1:0] C_SEL_STATUS = 2'd3;

    logic [31:0] w_rd_cnt  [NCH];
    logic [31:0] w_rd_cmp  [NCH];
    logic [31:0] w_rd_ctrl [NCH];
    logic [31:0] w_rd_stat [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [WIDTH-1:0] load_q, load_d;
            logic [WIDTH-1:0] cmp_q, cmp_d;
            logic [WIDTH-1:0] count_q, count_d;
            logic             en_q, en_d;
            logic [1:0]       mode_q, mode_d;
            logic [PSW-1:0]   pdiv_q, pdiv_d;
            logic [PSW-1:0]   presc_q, presc_d;
            logic             status_q, status_d;
            logic             w_sel;
            logic             w_tick;
            logic             w_expire;
            logic             w_reload;

            assign w_sel    = we && (ch == 3'(gi));
            assign w_tick   = en_q && (presc_q == pdiv_q);
            assign w_expire = w_tick && (count_q == '0);
            assign w_reload = (mode_q == 2'b01) || (mode_q == 2'b10);

            // Register writes are applied last so they override tick updates.
            always_comb begin
                load_d   = load_q;
                cmp_d    = cmp_q;
                count_d  = count_q;
                en_d     = en_q;
                mode_d   = mode_q;
                pdiv_d   = pdiv_q;
                presc_d  = presc_q;
                status_d = status_q;

                if (en_q) begin
                    presc_d = w_tick ? '0 : presc_q + 1'b1;
                end

                if (w_tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else if (w_reload) begin
                        count_d = load_q;
                    end else begin
                        en_d = 1'b0;
                    end
                end

                if (w_expire) begin
                    status_d = 1'b1;
                end else if (w_sel && (reg_sel == C_SEL_STATUS) && wdata[0]) begin
                    status_d = 1'b0;
                end

                if (w_sel) begin
                    case (reg_sel)
                        C_SEL_LOAD: begin
                            load_d  = wdata[WIDTH-1:0];
                            count_d = wdata[WIDTH-1:0];
                            presc_d = '0;
                        end
                        C_SEL_CMP: begin
                            cmp_d = wdata[WIDTH-1:0];
                        end
                        C_SEL_CTRL: begin
                            en_d    = wdata[0];
                            mode_d  = wdata[2:1];
                            pdiv_d  = wdata[8 +: PSW];
                            presc_d = '0;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    load_q   <= '0;
                    cmp_q    <= '0;
                    count_q  <= '0;
                    en_q     <= 1'b0;
                    mode_q   <= 2'b00;
                    pdiv_q   <= '0;
                    presc_q  <= '0;
                    status_q <= 1'b0;
                end else begin
                    load_q   <= load_d;
                    cmp_q    <= cmp_d;
                    count_q  <= count_d;
                    en_q     <= en_d;
                    mode_q   <= mode_d;
                    pdiv_q   <= pdiv_d;
                    presc_q  <= presc_d;
                    status_q <= status_d;
                end
            end

            assign cnt_out[gi*WIDTH +: WIDTH] = count_q;
            assign irq[gi] = status_q;
            assign pwm[gi] = en_q && (mode_q == 2'b10) && (count_q < cmp_q);

            assign w_rd_cnt[gi]  = 32'(count_q);
            assign w_rd_cmp[gi]  = 32'(cmp_q);
            assign w_rd_ctrl[gi] = {{(24-PSW){1'b0}}, pdiv_q, 5'b00000, mode_q, en_q};
            assign w_rd_stat[gi] = {31'b0, status_q};
        end
    endgenerate

    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Out-of-range channel indices match no channel and read as zero.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch == 3'(i)) begin
                case (reg_sel)
                    C_SEL_LOAD:   rdata_d = w_rd_cnt[i];
                    C_SEL_CMP:    rdata_d = w_rd_cmp[i];
                    C_SEL_CTRL:   rdata_d = w_rd_ctrl[i];
                    default:      rdata_d = w_rd_stat[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: doc/counter_xn.md
COUNTER_XN -- requirements
Module: counter_xn

Interface
REQ-001 SHALL provide parameter NCH, default 3, number of independent counter channels (1..8).
REQ-002 SHALL provide parameter WIDTH, default 32, counter/reload/compare width in bits (8..32).
REQ-003 SHALL provide parameter PSW, default 8, prescaler divisor width in bits (1..16).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 we  in  1  register write strobe, sampled on clk rising edge.
REQ-007 ch  in  3  channel index for write and read.
REQ-008 reg_sel  in  2  register select: 0 LOAD/COUNT, 1 CMP, 2 CTRL, 3 STATUS.
REQ-009 wdata  in  32  write data.
REQ-010 rdata  out  32  registered read data for {ch, reg_sel}.
REQ-011 cnt_out  out  NCH*WIDTH  live counts, channel i at bits [i*WIDTH +: WIDTH].
REQ-012 irq  out  NCH  per-channel sticky status (level).
REQ-013 pwm  out  NCH  per-channel PWM output.

Function
REQ-014 Each channel SHALL hold LOAD, CMP, COUNT (WIDTH bits), CTRL {EN bit0, MODE bits2:1, PDIV bits 8+PSW-1:8}, STATUS (1 bit) and a PSW-bit prescaler.
REQ-015 Writes SHALL use wdata[WIDTH-1:0] for LOAD/CMP; upper bits are ignored; CTRL fields beyond those in REQ-014 read as 0.
REQ-016 Write to LOAD SHALL set LOAD and COUNT to the value and clear the prescaler in the same edge.
REQ-017 Write to STATUS with wdata[0]=1 SHALL clear STATUS; wdata[0]=0 has no effect.
REQ-018 Write to CTRL SHALL clear the prescaler.
REQ-019 With ch >= NCH, writes SHALL be ignored and rdata SHALL read 0.
REQ-020 Prescaler SHALL count cycles while EN=1; a tick is asserted for one cycle every PDIV+1 cycles (PDIV=0 -> tick every cycle), prescaler wraps to 0 on tick.
REQ-021 On tick with COUNT != 0: COUNT <= COUNT-1.
REQ-022 On tick with COUNT == 0, MODE 00 (one-shot): STATUS <= 1, EN <= 0, COUNT holds 0.
REQ-023 On tick with COUNT == 0, MODE 01 (auto-reload) or 10 (PWM): STATUS <= 1, COUNT <= LOAD.
REQ-024 MODE 11 SHALL behave as MODE 00.
REQ-025 EN=0: COUNT, prescaler hold; STATUS holds.
REQ-026 pwm[i] SHALL equal EN & (MODE==10) & (COUNT < CMP), combinational from registers; CMP=0 -> constant 0; CMP > LOAD -> constant 1 while enabled.
REQ-027 Simultaneous STATUS clear write and set event on same channel: set wins (STATUS=1).
REQ-028 Simultaneous LOAD write and tick on same channel: write wins, no decrement that edge.
REQ-029 Simultaneous CTRL write and one-shot expiry: written CTRL value wins, STATUS still set.
REQ-030 rdata SHALL update each edge with: reg_sel 0 current COUNT, 1 CMP, 2 CTRL, 3 {31'b0,STATUS}, zero-extended; latency one cycle; write-then-read same register returns the new value one cycle after the write edge's following edge.
REQ-031 irq[i] SHALL equal STATUS of channel i.

Reset
REQ-032 rstn low SHALL immediately clear all LOAD, CMP, COUNT, CTRL, STATUS, prescalers and rdata to 0; hence cnt_out=0, irq=0, pwm=0.
REQ-033 Reset asserted mid-count SHALL abort; after release channels stay disabled until CTRL written.

Verification
REQ-034 Write LOAD=3, CTRL=0x001 (one-shot, PDIV 0) ch0 -> COUNT 3,2,1,0 on consecutive edges, next edge irq[0]=1, EN=0, COUNT stays 0.
REQ-035 ch1 LOAD=4, CTRL=0x203 (auto-reload, PDIV 2) -> decrement every 3 cycles, irq[1] rises after 15 cycles from enable, COUNT reloads to 4.
REQ-036 ch2 LOAD=9, CMP=3, CTRL=0x005 (PWM) -> pwm[2] high 3 of every 10 ticks; CMP=0 -> pwm stays 0.
REQ-037 STATUS W1C written on the same edge the channel expires -> irq remains 1; W1C one cycle later -> irq 0.
REQ-038 Write with ch=7 (NCH=3) -> no state change, rdata=0 next cycle; read COUNT of ch0 returns live value with 1-cycle latency.
REQ-039 Drop rstn asynchronously mid-count between edges -> all outputs 0 without clock edge; after release, counts hold 0 with no ticks.
